regfile_write_arbiter: RTL and testbench

Shares the register file's single write port among several writeback requesters (execute result, load result, debug/host) and runs a post-reset clear sequence over r1..r31. Sits between the writeback sources and the register file write port (`write_reg`, `write_data`, `write_enable`). It owns all register-file writes, so the register file needs no reset loop of its own.

---
 rtl/regfile_ctrl_pkg.sv | 25 ++
 rtl/regfile_write_arbiter_rr_arbiter.sv | 72 +++++++
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : regfile_ctrl_pkg
// Summary  : Shared constants and state type for the register-file write
//            control path (write arbiter and its clients).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // Requester slot assignment on the shared write port
    localparam int REQ_EXEC   = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_DEBUG  = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wr_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Summary  : Round-robin arbiter. Grants the first requester at or after the
//            priority pointer; the pointer moves past the grantee when the
//            grant is consumed (advance). Reusable for any shared port.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int               PTR_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N);
    localparam logic [PTR_W:0]   LAST_IDX = (PTR_W+1)'(N - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;
    logic             found;

    // Scan from the pointer upward with wrap; the first valid request wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to grantee+1 (mod N) only when the grant is taken
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            if ({1'b0, grant_idx} == LAST_IDX) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Summary  : Owns the register-file write port. After reset it clears
//            r1..r31 (optional), then arbitrates round-robin between the
//            writeback requesters. Writes to x0 are consumed but suppressed.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int XLEN       = 32,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][XLEN-1:0]       req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [REG_ADDR_W-1:0]              write_reg,
    output logic [XLEN-1:0]                    write_data,
    output logic                               write_enable,
    output logic                               init_done
);

    localparam wr_arb_state_t         RESET_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;
    localparam logic [REG_ADDR_W-1:0] LAST_CLEAR  = REG_ADDR_W'(NUM_REGS - 1);

    wr_arb_state_t         state_q,        state_d;
    logic [REG_ADDR_W-1:0] clr_cnt_q,      clr_cnt_d;
    logic [REG_ADDR_W-1:0] write_reg_q,    write_reg_d;
    logic [XLEN-1:0]       write_data_q,   write_data_d;
    logic                  write_enable_q, write_enable_d;

    logic                  arb_en;
    logic [NUM_REQ-1:0]    arb_req;
    logic [NUM_REQ-1:0]    grant;
    logic                  handshake;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;

    // Grants only in RUN; reset is included so ready is low while it is held
    assign arb_en    = (state_q == ST_RUN) && !reset;
    assign arb_req   = req_valid & {NUM_REQ{arb_en}};
    assign handshake = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (handshake),
        .grant   (grant)
    );

    // One-hot grant mux of the winning requester's address and data
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i];
                sel_data = sel_data | req_data[i];
            end
        end
    end

    // Next-state: clear sweep in INIT, captured handshake in RUN
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        write_enable_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                write_enable_d = 1'b1;
                write_reg_d    = clr_cnt_q;
                write_data_d   = '0;
                clr_cnt_d      = clr_cnt_q + REG_ADDR_W'(1);
                if (clr_cnt_q == LAST_CLEAR) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (handshake) begin
                    write_reg_d    = sel_addr;
                    write_data_d   = sel_data;
                    // x0 is hardwired zero: accept the request, drop the write
                    write_enable_d = (sel_addr != '0);
                end
            end
        endcase
    end

    // State, clear counter and write-port output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RESET_STATE;
            clr_cnt_q      <= REG_ADDR_W'(1);
            write_reg_q    <= '0;
            write_data_q   <= '0;
            write_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            write_enable_q <= write_enable_d;
        end
    end

    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign write_enable = write_enable_q;
    assign init_done    = (state_q == ST_RUN) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Summary  : Scoreboard bench for regfile_write_arbiter. A reference model
//            predicts grants and register-file writes; a monitor compares the
//            write port against the queued expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic                clk       = 1'b0;
    logic                reset     = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0][4:0]   req_addr  = '0;
    logic [N-1:0][W-1:0] req_data  = '0;
    logic [N-1:0]        req_ready;
    logic [4:0]          write_reg;
    logic [W-1:0]        write_data;
    logic                write_enable;
    logic                init_done;

    // Second instance built without the clear sequence
    logic [N-1:0]        b_req_valid = '0;
    logic [N-1:0][4:0]   b_req_addr  = '0;
    logic [N-1:0][W-1:0] b_req_data  = '0;
    logic [N-1:0]        b_req_ready;
    logic [4:0]          b_write_reg;
    logic [W-1:0]        b_write_data;
    logic                b_write_enable;
    logic                b_init_done;

    regfile_write_arbiter #(.NUM_REQ(N), .XLEN(W), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .write_reg(write_reg),
        .write_data(write_data), .write_enable(write_enable), .init_done(init_done)
    );

    regfile_write_arbiter #(.NUM_REQ(N), .XLEN(W), .INIT_CLEAR(1'b0)) dut_noinit (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_data(b_req_data), .req_ready(b_req_ready), .write_reg(b_write_reg),
        .write_data(b_write_data), .write_enable(b_write_enable), .init_done(b_init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [36:0]  exp_q[$];
    int           m_ptr      = 0;
    int           m_clr_left = 31;
    int           m_next_clr = 1;
    logic [N-1:0] granted    = '0;

    // Predict each cycle's grant and the write it must produce next cycle
    always @(negedge clk) begin
        logic [N-1:0] exp_g;
        exp_g   = '0;
        granted = req_ready;
        if (reset) begin
            m_ptr      = 0;
            m_clr_left = 31;
            m_next_clr = 1;
            exp_q.delete();
        end else if (m_clr_left > 0) begin
            check("init_ready", req_ready, 0);
            check("init_done_low", init_done, 0);
            exp_q.push_back({5'(m_next_clr), 32'h0});
            m_next_clr++;
            m_clr_left--;
        end else begin
            check("init_done_high", init_done, 1);
            for (int k = 0; k < N; k++) begin
                if (exp_g == '0 && req_valid[(m_ptr + k) % N]) begin
                    exp_g[(m_ptr + k) % N] = 1'b1;
                end
            end
            check("req_ready", req_ready, exp_g);
            for (int j = 0; j < N; j++) begin
                if (exp_g[j]) begin
                    if (req_addr[j] != 5'd0) begin
                        exp_q.push_back({req_addr[j], req_data[j]});
                    end
                    m_ptr = (j + 1) % N;
                end
            end
        end
    end

    // Monitor: every write on the port must match the oldest expectation
    always @(negedge clk) begin
        logic [36:0] e;
        if (!reset && write_enable) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                e = exp_q.pop_front();
                check("write_reg", write_reg, e[36:32]);
                check("write_data", write_data, e[31:0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_values_check();
        check("rst_write_enable", write_enable, 0);
        check("rst_write_reg", write_reg, 0);
        check("rst_write_data", write_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_init_done", init_done, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 reset_values_check();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Present requests and hold each until granted (bounded)
    task automatic issue(input logic [N-1:0] mask,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        req_addr[0] = a0; req_addr[1] = a1; req_addr[2] = a2;
        req_data[0] = d0; req_data[1] = d1; req_data[2] = d2;
        req_valid   = mask;
        for (int c = 0; c < 60 && req_valid != '0; c++) begin
            @(posedge clk);
            #1 req_valid = req_valid & ~granted;
        end
        if (req_valid != '0) begin
            fail_now("grant_timeout");
            req_valid = '0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #7 reset_values_check();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(33);

        issue(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        idle(2);

        pulse_reset();
        idle(33);
        issue(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
        issue(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h55, 32'h0);
        issue(3'b101, 5'd7, 5'd0, 5'd9, 32'hAA, 32'h0, 32'hBB);
        idle(2);

        // Reset in the middle of the clear sweep
        pulse_reset();
        idle(16);
        pulse_reset();
        idle(33);

        // Reset while req 2 is being granted: that write must never appear
        req_addr[2] = 5'd12;
        req_data[2] = 32'hCAFE_0002;
        req_valid   = 3'b100;
        #2 reset = 1'b1;
        #1 reset_values_check();
        @(posedge clk);
        #1 reset = 1'b0;
        issue(3'b100, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'hCAFE_0002);

        // Randomized traffic; requesters hold until granted
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || granted[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        req_valid[i] = 1'b1;
                        req_addr[i]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                        req_data[i]  = $urandom;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        req_valid = '0;
        idle(3);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // INIT_CLEAR=0 instance: grant in the very first cycle after reset
    initial begin
        b_req_valid   = 3'b100;
        b_req_addr[2] = 5'd31;
        b_req_data[2] = 32'h1;
        @(negedge reset);
        @(negedge clk);
        check("noinit_ready_first", b_req_ready, 3'b100);
        check("noinit_init_done", b_init_done, 1);
        check("noinit_we_first", b_write_enable, 0);
        @(posedge clk);
        #1 b_req_valid = '0;
        @(negedge clk);
        check("noinit_we", b_write_enable, 1);
        check("noinit_reg", b_write_reg, 31);
        check("noinit_data", b_write_data, 32'h1);
        @(negedge clk);
        check("noinit_we_single", b_write_enable, 0);
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
